// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state type and access-size helpers for the load/store unit.
// Rev 1.0
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] f);
    case (f)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] f);
    case (f)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: aligns a two-word read window by byte offset and sign/zero-extends it.
// Rev 1.0
`default_nettype none

module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] word;
  assign word = 32'(data_i >> {off_i, 3'b000});

  always_comb begin
    result_o = word;
    case (funct3_i)
      F3_B:    result_o = {{24{word[7]}}, word[7:0]};
      F3_BU:   result_o = {24'b0, word[7:0]};
      F3_H:    result_o = {{16{word[15]}}, word[15:0]};
      F3_HU:   result_o = {16'b0, word[15:0]};
      default: result_o = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit driving d_mem; splits misaligned accesses into two word cycles.
// Rev 1.0
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned SIZE_POW2 = 9,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_WE,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [32:0] MEM_END = {1'b0, BASE_ADDR} + (33'd1 << SIZE_POW2);

  lsu_state_t  state_q, state_d;
  logic        accept, fault, save;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [7:0]  mask8;
  logic [63:0] wd64;
  logic [32:0] end_addr;

  logic [29:0] wa_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] whi_q;
  logic [3:0]  mhi_q;
  logic [31:0] lo_q;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  logic [63:0] ext_data;
  logic [1:0]  ext_off;
  logic [2:0]  ext_f3;
  logic [31:0] ext_result;

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  assign off      = req_addr[1:0];
  assign size     = size_bytes(req_funct3[1:0]);
  assign mask8    = {4'b0000, size_mask(req_funct3[1:0])} << off;
  assign wd64     = {32'b0, req_wdata} << {off, 3'b000};
  // 33-bit end address so accesses near the top of the 32-bit space cannot wrap past the check
  assign end_addr = {1'b0, req_addr} + {30'b0, size};

  assign fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_we && req_funct3[2]) || (req_addr < BASE_ADDR) ||
                 (end_addr > MEM_END);

  assign ext_data = (state_q == SPLIT) ? {mem_RD, lo_q} : {32'b0, mem_RD};
  assign ext_off  = (state_q == SPLIT) ? off_q : off;
  assign ext_f3   = (state_q == SPLIT) ? f3_q : req_funct3;

  lsu_load_ext u_load_ext (
    .data_i   (ext_data),
    .off_i    (ext_off),
    .funct3_i (ext_f3),
    .result_o (ext_result)
  );

  always_comb begin
    state_d      = state_q;
    save         = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'b0;
    resp_fault_d = 1'b0;
    mem_WE       = 1'b0;
    mem_byte_en  = 4'b0000;
    mem_A        = {req_addr[31:2], 2'b00};
    mem_WD       = wd64[31:0];
    case (state_q)
      IDLE: begin
        if (accept) begin
          resp_valid_d = 1'b1;
          if (fault) begin
            resp_fault_d = 1'b1;
          end else begin
            mem_WE      = req_we;
            mem_byte_en = mask8[3:0];
            if (mask8[7:4] != 4'b0000) begin
              state_d      = SPLIT;
              save         = 1'b1;
              resp_valid_d = 1'b0;
            end else if (!req_we) begin
              resp_rdata_d = ext_result;
            end
          end
        end
      end
      SPLIT: begin
        state_d      = IDLE;
        mem_A        = {wa_q + 30'd1, 2'b00};
        mem_WD       = whi_q;
        // Reset abandons the second half, so it must not reach memory either
        if (rst_n) begin
          mem_WE      = we_q;
          mem_byte_en = mhi_q;
        end
        resp_valid_d = 1'b1;
        if (!we_q) resp_rdata_d = ext_result;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      if (save) begin
        wa_q  <= req_addr[31:2];
        off_q <= off;
        f3_q  <= req_funct3;
        we_q  <= req_we;
        whi_q <= wd64[63:32];
        mhi_q <= mask8[7:4];
        lo_q  <= mem_RD;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a byte-enabled word memory model.
// Rev 1.0
`default_nettype none

module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_WE;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  int n_checks;
  int n_errors;

  lsu #(
    .SIZE_POW2 (9),
    .BASE_ADDR (32'h8000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_fault  (resp_fault),
    .mem_WE      (mem_WE),
    .mem_byte_en (mem_byte_en),
    .mem_A       (mem_A),
    .mem_WD      (mem_WD),
    .mem_RD      (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 512-byte data memory: asynchronous read, byte-enabled synchronous write
  logic [31:0] mem [0:127];
  assign mem_RD = mem[mem_A[8:2]];
  always @(posedge clk) begin
    if (mem_WE) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_en[b]) mem[mem_A[8:2]][8*b +: 8] <= mem_WD[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_fault", 32'(resp_fault), 0);
    check("rst_mem_we", 32'(mem_WE), 0);
    check("rst_byte_en", 32'(mem_byte_en), 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(req_ready), 1);

    // SW then LW at 0x8000_0010
    drive(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF);
    check("sw_be", 32'(mem_byte_en), 32'hF);
    check("sw_we", 32'(mem_WE), 1);
    check("sw_a", mem_A, 32'h8000_0010);
    check("sw_wd", mem_WD, 32'hDEAD_BEEF);
    step();
    check("sw_resp_valid", 32'(resp_valid), 1);
    check("sw_resp_fault", 32'(resp_fault), 0);
    check("sw_resp_rdata", resp_rdata, 0);
    check("idle_be", 32'(mem_byte_en), 0);
    check("idle_we", 32'(mem_WE), 0);
    drive(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    check("lw_we", 32'(mem_WE), 0);
    step();
    check("lw_valid", 32'(resp_valid), 1);
    check("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
    step();
    check("resp_pulse", 32'(resp_valid), 0);

    // SB 0x8000_0013, then LB / LBU
    drive(1'b1, 3'b000, 32'h8000_0013, 32'h0000_00A5);
    check("sb_be", 32'(mem_byte_en), 32'h8);
    check("sb_wd", mem_WD, 32'hA500_0000);
    check("sb_a", mem_A, 32'h8000_0010);
    step();
    drive(1'b0, 3'b000, 32'h8000_0013, 32'h0);
    step();
    check("lb_rdata", resp_rdata, 32'hFFFF_FFA5);
    drive(1'b0, 3'b100, 32'h8000_0013, 32'h0);
    step();
    check("lbu_rdata", resp_rdata, 32'h0000_00A5);

    // Misaligned LW across two words
    drive(1'b1, 3'b010, 32'h8000_0004, 32'h4433_2211);
    step();
    drive(1'b1, 3'b010, 32'h8000_0008, 32'h8877_6655);
    step();
    drive(1'b0, 3'b010, 32'h8000_0006, 32'h0);
    check("mlw_a1", mem_A, 32'h8000_0004);
    check("mlw_be1", 32'(mem_byte_en), 32'hC);
    step();
    check("mlw_ready_split", 32'(req_ready), 0);
    check("mlw_a2", mem_A, 32'h8000_0008);
    check("mlw_be2", 32'(mem_byte_en), 32'h3);
    check("mlw_no_early_resp", 32'(resp_valid), 0);
    step();
    check("mlw_valid", 32'(resp_valid), 1);
    check("mlw_rdata", resp_rdata, 32'h6655_4433);
    check("mlw_ready_back", 32'(req_ready), 1);

    // Misaligned SH 0x8000_0007, then read back as LHU / LH
    drive(1'b1, 3'b001, 32'h8000_0007, 32'h0000_BEEF);
    check("msh_a1", mem_A, 32'h8000_0004);
    check("msh_be1", 32'(mem_byte_en), 32'h8);
    check("msh_wd1", 32'(mem_WD[31:24]), 32'hEF);
    step();
    check("msh_a2", mem_A, 32'h8000_0008);
    check("msh_be2", 32'(mem_byte_en), 32'h1);
    check("msh_wd2", 32'(mem_WD[7:0]), 32'hBE);
    check("msh_we2", 32'(mem_WE), 1);
    step();
    check("msh_valid", 32'(resp_valid), 1);
    drive(1'b0, 3'b101, 32'h8000_0007, 32'h0);
    step();
    step();
    check("mlhu_rdata", resp_rdata, 32'h0000_BEEF);
    drive(1'b0, 3'b001, 32'h8000_0007, 32'h0);
    step();
    step();
    check("mlh_rdata", resp_rdata, 32'hFFFF_BEEF);

    // Fault cases
    drive(1'b0, 3'b010, 32'h8000_01FE, 32'h0);
    check("f_range_we", 32'(mem_WE), 0);
    step();
    check("f_range_valid", 32'(resp_valid), 1);
    check("f_range_fault", 32'(resp_fault), 1);
    check("f_range_rdata", resp_rdata, 0);
    check("f_range_ready", 32'(req_ready), 1);
    drive(1'b1, 3'b010, 32'h7FFF_FFFC, 32'h1234_5678);
    check("f_low_we", 32'(mem_WE), 0);
    step();
    check("f_low_fault", 32'(resp_fault), 1);
    check("f_low_valid", 32'(resp_valid), 1);
    drive(1'b0, 3'b011, 32'h8000_0010, 32'h0);
    step();
    check("f_f3_fault", 32'(resp_fault), 1);
    check("f_f3_rdata", resp_rdata, 0);
    drive(1'b1, 3'b100, 32'h8000_0010, 32'h0000_0055);
    check("f_sbu_we", 32'(mem_WE), 0);
    step();
    check("f_sbu_fault", 32'(resp_fault), 1);
    drive(1'b0, 3'b010, 32'h8000_01FC, 32'h0);
    step();
    check("top_word_nofault", 32'(resp_fault), 0);
    check("top_word_valid", 32'(resp_valid), 1);

    // Misaligned SW with reset asserted during SPLIT
    drive(1'b1, 3'b010, 32'h8000_0005, 32'h1122_3344);
    check("rs_be1", 32'(mem_byte_en), 32'hE);
    check("rs_wd1", mem_WD, 32'h2233_4400);
    step();
    rst_n = 1'b0;
    #1;
    check("rs_we", 32'(mem_WE), 0);
    check("rs_be", 32'(mem_byte_en), 0);
    check("rs_ready", 32'(req_ready), 0);
    step();
    check("rs_valid", 32'(resp_valid), 0);
    rst_n = 1'b1;
    #1;
    check("rs_ready_after", 32'(req_ready), 1);
    drive(1'b0, 3'b010, 32'h8000_0008, 32'h0);
    check("rs_idle_be", 32'(mem_byte_en), 32'hF);
    step();
    check("rs_valid_after", 32'(resp_valid), 1);
    check("rs_no_second_write", resp_rdata, 32'h8877_66BE);
    drive(1'b0, 3'b010, 32'h8000_0004, 32'h0);
    step();
    check("rs_first_half", resp_rdata, 32'h2233_4411);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting in the MEM stage between the pipeline and `d_mem`. It is the initiator side of the data-memory interface. It accepts one load or store request per handshake, derives word address, byte enables and lane-aligned write data, and splits misaligned accesses into two word transactions. Load data is returned merged and sign/zero-extended, and out-of-range or illegal accesses are flagged as faults.

## Interface
- `SIZE_POW2`, 9: data memory is 2^SIZE_POW2 bytes; used for the range check.
- `BASE_ADDR`, 32'h8000_0000: first byte address of data memory.
- Reset is synchronous and active-low: `rst_n` is sampled only on `posedge clk`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse per accepted request.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_fault` out 1: range or funct3 fault.
- `mem_WE` out 1: memory write enable.
- `mem_byte_en` out 4: memory byte enables.
- `mem_A` out 32: word-aligned memory address.
- `mem_WD` out 32: lane-aligned write data.
- `mem_RD` in 32: asynchronous read data from memory.

## Operation
- States: IDLE, SPLIT.
- `req_ready` is 1 in IDLE with `rst_n` high; 0 in SPLIT and while `rst_n` is low.
- **Accept:** a request is accepted when `req_valid && req_ready`.
- **Definitions:**
  - off = `addr[1:0]`.
  - size = 1/2/4 bytes from `funct3[1:0]`.
  - mask8 = ((1<<size)-1) << off (8 bits).
  - wd64 = {32'b0, wdata} << 8·off.
- **Fault:** asserted if any of the following holds.
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3[2] = 1.
  - addr < BASE_ADDR.
  - addr + size > BASE_ADDR + 2^SIZE_POW2, computed in 33 bits (no wrap-around).
  - On a fault: no memory write, no SPLIT, response carries fault = 1 and rdata = 0.
- **IDLE accept, no fault:**
  - `mem_A` = {addr[31:2], 2'b00}.
  - `mem_byte_en` = mask8[3:0].
  - `mem_WD` = wd64[31:0].
  - `mem_WE` = `req_we`.
  - Read data is captured as the low word.
  - If mask8[7:4] ≠ 0, go to SPLIT and save addr, off, funct3, we, and wd64[63:32].
- **SPLIT:**
  - `mem_A` = saved word address + 4.
  - `mem_byte_en` = mask8[7:4].
  - `mem_WD` = saved upper word.
  - `mem_WE` = saved we.
  - Read data is captured as the high word; return to IDLE.
- **Load result:** ({hi, lo} >> 8·off) truncated to size, sign-extended if funct3[2] = 0, else zero-extended. Aligned loads use hi = 0.
- **Idle outputs:** when not accepting and not in SPLIT, `mem_WE` = 0 and `mem_byte_en` = 0; `mem_A` and `mem_WD` are don't-care.
- **Reset during SPLIT:** the second half is abandoned. A split store leaves its first half written. No response is produced.

## Timing
- Memory outputs are combinational from the request (IDLE) or saved state (SPLIT). The memory write lands on the same clock edge.
- `resp_valid`, `resp_rdata` and `resp_fault` are registered.
- Aligned or faulting request accepted in cycle N: response in cycle N+1.
- Misaligned request accepted in cycle N: SPLIT in N+1, response in N+2.
- Aligned requests sustain one per cycle.
- The response has no backpressure.
- Reset values: state IDLE, `resp_valid` 0, `resp_rdata` 0, `resp_fault` 0, `mem_WE` 0, `mem_byte_en` 0, `req_ready` 0 while in reset.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - `lsu_state_t` enum {IDLE, SPLIT}.
- Sub-module `lsu_load_ext`, combinational: {hi, lo}, off, funct3 → extended 32-bit result.

## Test plan
- SW 0x8000_0010 data 0xDEADBEEF, then LW 0x8000_0010:
  - Store: byte_en 1111 for one cycle; resp next cycle with fault 0.
  - Load: rdata 0xDEADBEEF.
- SB 0x8000_0013 data 0xA5:
  - byte_en 1000, WD 0xA500_0000.
  - LB same address → 0xFFFF_FFA5; LBU → 0x0000_00A5.
- Words at 0x8000_0004 = 0x44332211 and 0x8000_0008 = 0x88776655; LW 0x8000_0006:
  - `req_ready` low for 1 cycle.
  - A = 0x…04 then 0x…08.
  - resp at N+2 with rdata 0x66554433.
- SH 0x8000_0007 data 0xBEEF:
  - Cycle 1: A 0x8000_0004, byte_en 1000, WD[31:24] 0xEF.
  - Cycle 2: A 0x8000_0008, byte_en 0001, WD[7:0] 0xBE.
- Fault cases, each giving fault 1, rdata 0, `mem_WE` never high, resp at N+1:
  - LW 0x8000_01FE.
  - SW 0x7FFF_FFFC.
  - funct3 011.
- Misaligned SW 0x8000_0005 with `rst_n` low during SPLIT:
  - No second write; `resp_valid` stays 0.
  - After release, `req_ready` 1 and state IDLE.
